// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment types, active-low off levels and hex glyph table.
package seg_pkg;

    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_OFF = 7'h7F;
    localparam logic [7:0]   AN_OFF  = 8'hFF;

    localparam seg_pattern_t HEX_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low segment pattern, with blank override.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0]   nibble,
    input  logic         blank,
    output seg_pattern_t pattern
);

    assign pattern = blank ? SEG_OFF : HEX_LUT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero blanking, anode guard interval and frame-done pulse.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 131072,
    parameter int GUARD    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    logic [PW-1:0]           pc_q, pc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                    pv_q, pv_d;
    seg_pattern_t            seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    fd_q, fd_d;
    logic                    tick, boundary, commit, lit, blank_nib;
    logic [3:0]              nib;
    seg_pattern_t            pat;

    always_comb begin
        tick        = enable && pc_q == PW'(SCAN_DIV - 1);
        boundary    = tick && idx_q == IW'(N_DIGITS - 1);
        commit      = boundary && pv_q;
        pc_d        = !enable ? pc_q : tick ? '0 : pc_q + 1'b1;
        idx_d       = !tick ? idx_q : boundary ? '0 : idx_q + 1'b1;
        // commit takes the pre-edge pending copy; a coincident load re-arms pv
        act_data_d  = commit ? pend_data_q : act_data_q;
        act_dp_d    = commit ? pend_dp_q : act_dp_q;
        pend_data_d = load ? data_in : pend_data_q;
        pend_dp_d   = load ? dp_in : pend_dp_q;
        pv_d        = load || (pv_q && !commit);
        lit         = enable && pc_q >= PW'(GUARD);
        nib         = act_data_q[{idx_q, 2'b00} +: 4];
        blank_nib   = blank_lz && idx_q != '0 && (act_data_q >> {idx_q, 2'b00}) == '0;
        seg_d       = pat;
        an_d        = lit ? ~(N_DIGITS'(1) << idx_q) : AN_OFF[N_DIGITS-1:0];
        dp_d        = lit ? ~act_dp_q[idx_q] : 1'b1;
        fd_d        = boundary;
    end

    seg_hex_decode u_dec (
        .nibble  (nib),
        .blank   (blank_nib || !lit),
        .pattern (pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            pv_q        <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= AN_OFF[N_DIGITS-1:0];
            fd_q        <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pv_q        <= pv_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: cycle-accurate check of seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

    logic        clk = 0, rst = 1, enable = 0, load = 0, blank_lz = 0;
    logic [15:0] data_in = 0;
    logic [3:0]  dp_in = 0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    int          n_tests = 0, n_fail = 0;

    logic [6:0] hex_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          m_pos;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    logic        m_pv;
    logic        cur_en = 1, cur_lz = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // m_pos counts enabled cycles since reset; slot position and digit follow from plain arithmetic
    task automatic step(input logic r, input logic e, input logic l, input logic lz,
                        input logic [15:0] d, input logic [3:0] p);
        int pcm, dig;
        logic lit, blk, ed, ef;
        logic [6:0] es;
        logic [3:0] ea;
        rst = r; enable = e; load = l; blank_lz = lz; data_in = d; dp_in = p;
        pcm = m_pos % 8;
        dig = (m_pos / 8) % 4;
        lit = !r && e && pcm >= 2;
        blk = lz && dig > 0 && ((m_act >> (4 * dig)) == 16'h0);
        ea  = lit ? ~(4'd1 << dig) : 4'hF;
        es  = lit ? (blk ? 7'h7F : hex_ref[m_act[4*dig +: 4]]) : 7'h7F;
        ed  = lit ? ~m_adp[dig] : 1'b1;
        ef  = !r && e && pcm == 7 && dig == 3;
        @(posedge clk);
        if (r) begin
            m_pos = 0; m_pend = 0; m_act = 0; m_pdp = 0; m_adp = 0; m_pv = 0;
        end else begin
            if (ef && m_pv) begin
                m_act = m_pend; m_adp = m_pdp; m_pv = 0;
            end
            if (l) begin
                m_pend = d; m_pdp = p; m_pv = 1;
            end
            if (e) m_pos++;
        end
        #1;
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("dp", 32'(dp), 32'(ed));
        check("frame_done", 32'(frame_done), 32'(ef));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, cur_en, 0, cur_lz, 16'h0, 4'h0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        step(0, cur_en, 1, cur_lz, d, p);
    endtask

    initial begin
        m_pos = 0; m_pend = 0; m_act = 0; m_pdp = 0; m_adp = 0; m_pv = 0;
        repeat (3) step(1, 1, 0, 0, 16'h0, 4'h0);
        run(21);
        repeat (3) step(1, 1, 0, 0, 16'h0, 4'h0);
        run(5);
        do_load(16'h12AF, 4'b0100);
        run(70);
        for (int i = 0; i < 64 && m_pos % 32 != 10; i++) run(1);
        do_load(16'h1111, 4'h0);
        run(5);
        do_load(16'h2222, 4'h1);
        run(80);
        cur_lz = 1;
        do_load(16'h0030, 4'h8);
        run(70);
        do_load(16'h0000, 4'h0);
        run(70);
        cur_lz = 0;
        do_load(16'h5555, 4'h0);
        for (int i = 0; i < 64 && m_pos % 32 != 31; i++) run(1);
        do_load(16'hBEEF, 4'hA);
        run(70);
        for (int i = 0; i < 16 && m_pos % 8 != 4; i++) run(1);
        cur_en = 0;
        run(10);
        do_load(16'h9876, 4'h3);
        run(10);
        cur_en = 1;
        run(80);
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] mask;
            case ($urandom_range(3))
                0: mask = 16'hFFFF;
                1: mask = 16'h00FF;
                2: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            if ($urandom_range(29) == 0) cur_en = ~cur_en;
            if ($urandom_range(199) == 0) cur_lz = ~cur_lz;
            step($urandom_range(499) == 0, cur_en, $urandom_range(19) == 0, cur_lz,
                 16'($urandom) & mask, 4'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller, the successor to the fixed 4-digit `seg_display`. It runs from the system clock using an internal prescaler tick, not a divided clock. Frame-synchronous double-buffering prevents tearing. It adds per-digit decimal points, leading-zero blanking, an anode guard interval and a frame-done pulse. It sits in the board wrapper between the processor's register-write data and the Basys3 display pins.

## Interface
- `N_DIGITS`, 4: number of digits; legal range 1..8.
- `SCAN_DIV`, 131072: system-clock cycles per digit slot; must be at least 2.
- `GUARD`, 1024: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than `SCAN_DIV`.
- `clk` in 1: system clock. The block has one clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 1 = scanning; 0 = display dark and scan frozen.
- `load` in 1: one-cycle strobe that captures `data_in` and `dp_in` into the pending buffer.
- `data_in` in 4*N_DIGITS: hex nibbles; nibble i drives digit i (digit 0 is the rightmost).
- `dp_in` in N_DIGITS: decimal-point request per digit; 1 = lit.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `seg` out 7: active-low segments; bit 0 = a through bit 6 = g.
- `dp` out 1: active-low decimal point.
- `an` out N_DIGITS: active-low anodes.
- `frame_done` out 1: one-cycle pulse per completed frame.

## Operation
- **Prescaler `pc`:** counts 0..SCAN_DIV-1 while `enable`=1 and wraps.
  - `tick` = `enable` & (`pc`==SCAN_DIV-1).
- **Digit index `idx`:** counts 0..N_DIGITS-1 and advances on `tick`.
  - Wraps from N_DIGITS-1 to 0; that tick is the frame boundary.
- **Buffers:** `pending` (data, dp, `pv` valid flag) and `active` (data, dp).
  - `load` writes `pending` and sets `pv`. A later `load` before commit overwrites `pending`; last writer wins.
  - At a frame boundary with `pv`=1, `active` ← `pending` and `pv` is cleared.
- **Simultaneous load and commit:**
  - The commit uses the pre-edge `pending`.
  - The new `load` value lands in `pending` with `pv`=1 and commits at the next boundary.
- **Decode:** hex digits use standard active-low patterns.
  - 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
- **Leading-zero blanking:** digit i>0 is blanked (`seg`=7'h7F) when `blank_lz`=1 and `active` nibbles i..N_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - The decimal point of a blanked digit still follows `active` dp.
- **Output drive:**
  - `pc` < GUARD, or `enable`=0: `an` is all ones, `seg`=7'h7F, `dp`=1.
  - Otherwise `an` = ~(1<<`idx`), `seg` = decode of the active nibble[`idx`], `dp` = ~active_dp[`idx`].
- **`enable`=0:** `pc` and `idx` hold and commits stall.
  - `load` still captures into `pending`.
  - Scanning resumes from the held state.

## Timing
- All outputs are registered, with 1-cycle latency from the `pc`/`idx`/`active` state.
- `frame_done` is high for exactly the one cycle after the frame-boundary tick edge.
- **Digit slot:**
  - Slot length is SCAN_DIV cycles; the anode is lit for SCAN_DIV-GUARD of them.
  - Frame period is N_DIGITS*SCAN_DIV cycles.
- **Load-to-display latency:** at most one frame plus 1 cycle after the commit boundary.
- **Reset values** (at the first edge with `rst`=1; reset is honoured mid-frame and mid-guard):
  - `pc`=0, `idx`=0, `pv`=0, `pending`=0, `active`=0.
  - `seg`=7'h7F, `dp`=1, `an` all ones, `frame_done`=0.
  - After `rst` deasserts, the first anode drives at cycle GUARD+1 (digit 0).

## Structure
- **Package `seg_pkg`:**
  - active-low constants `SEG_OFF`=7'h7F and `AN_OFF`;
  - the 16-entry hex pattern constant array;
  - the `seg_pattern_t` typedef (logic [6:0]).
- **Sub-module `seg_hex_decode`:** combinational nibble → pattern, with a blank input. It is reused elsewhere in the wrapper.
- **Top:** prescaler, index counter, buffer/commit logic, LZ mask and output registers in one module of about 150–250 lines.

## Test plan
Benches use N_DIGITS=4, SCAN_DIV=8, GUARD=2.
1. **Reset:** hold `rst` 3 cycles mid-scan → next edge `seg`=7'h7F, `an`=4'hF, `dp`=1, `frame_done`=0; `an`=4'hE first seen 3 cycles after release.
2. **Load and scan:** `load` 16'h12AF with `dp_in`=4'b0100 → after commit, `an` sequence E,D,B,7 shows F(0001110), A(0001000), 2 with `dp`=0, 1(1111001). Each anode is low 6 of 8 cycles; `frame_done` pulses every 32 cycles.
3. **Tearing:** `load` 16'h1111 mid-frame, then 16'h2222 before the boundary → no digit ever shows 1; the whole next frame shows 2.
4. **Leading-zero blanking:** `blank_lz`=1 with data 16'h0030 → digits 3 and 2 blank, digit 1 shows 3, digit 0 shows 0. Data 16'h0000 → only digit 0 lit, showing 0.
5. **Load at boundary:** `load` 16'hBEEF in the same cycle as the boundary tick with `pv`=1 holding 16'h5555 → this frame shows 5555 and the next shows BEEF.
6. **Enable pause:** `enable`=0 for 20 cycles mid-slot → `an`=4'hF throughout and no `frame_done`; on re-enable, the same digit resumes with `pc` continuing from the held value.
